// File: rtl/noc_wb_bridge.sv
// noc_wb_bridge: NoC endpoint that converts request packets into single
// Wishbone master transactions. It returns one response packet per request.
// Only one request is in flight at a time, and there is no data buffering.
module noc_wb_bridge #(
  parameter int         FLIT_WIDTH = 32,
  parameter logic [4:0] ID         = 5'd0,
  parameter int         TIMEOUT    = 255,
  parameter int         MAX_RTY    = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  // request flits from the router
  input  logic [FLIT_WIDTH-1:0] noc_in_flit,
  input  logic                  noc_in_last,
  input  logic                  noc_in_valid,
  output logic                  noc_in_ready,
  // response flits to the router
  output logic [FLIT_WIDTH-1:0] noc_out_flit,
  output logic                  noc_out_last,
  output logic                  noc_out_valid,
  input  logic                  noc_out_ready,
  // Wishbone master
  output logic [31:0]           wb_adr_o,
  output logic [31:0]           wb_dat_o,
  output logic [3:0]            wb_sel_o,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic [2:0]            wb_cti_o,
  output logic [1:0]            wb_bte_o,
  input  logic                  wb_ack_i,
  input  logic                  wb_err_i,
  input  logic                  wb_rty_i,
  input  logic [31:0]           wb_dat_i
);

  localparam logic [2:0] CLASS_REQ = 3'd2;
  localparam logic [2:0] CLASS_RSP = 3'd3;
  localparam logic [9:0] TMO_LIM   = 10'(TIMEOUT);
  localparam logic [7:0] RTY_LIM   = 8'(MAX_RTY);

  typedef enum logic [2:0] {
    RX_HDR, RX_ADR, RX_DAT, DRAIN, WB_REQ, RTY_GAP, TX_HDR, TX_DAT
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  src_q, src_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] wdat_q, wdat_d;
  logic [31:0] rdat_q, rdat_d;
  logic        err_q, err_d;
  logic        pend_q, pend_d;   // drain target: 1 = perform the bus access afterwards
  logic [9:0]  tmo_q, tmo_d;
  logic [7:0]  rty_q, rty_d;

  // State and captured request/response fields.
  // The reset is asynchronous, so cyc/stb drop as soon as it is asserted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RX_HDR;
      src_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      adr_q   <= '0;
      wdat_q  <= '0;
      rdat_q  <= '0;
      err_q   <= 1'b0;
      pend_q  <= 1'b0;
      tmo_q   <= '0;
      rty_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      rdat_q  <= rdat_d;
      err_q   <= err_d;
      pend_q  <= pend_d;
      tmo_q   <= tmo_d;
      rty_q   <= rty_d;
    end
  end

  // Next-state logic: packet parsing, the bus transaction with retry and
  // timeout, and the response handshake.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    we_d    = we_q;
    sel_d   = sel_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    rdat_d  = rdat_q;
    err_d   = err_q;
    pend_d  = pend_q;
    rty_d   = rty_q;
    tmo_d   = '0;  // held at zero outside WB_REQ, so every entry starts from 0
    case (state_q)
      RX_HDR: begin
        if (noc_in_valid) begin
          if (noc_in_last || (noc_in_flit[26:24] != CLASS_REQ)) begin
            // Not a usable request: swallow it without a response.
            pend_d = 1'b0;
            if (!noc_in_last) state_d = DRAIN;
          end else begin
            src_d   = noc_in_flit[23:19];
            we_d    = noc_in_flit[18];
            sel_d   = noc_in_flit[16:13];
            err_d   = 1'b0;
            rty_d   = '0;
            state_d = RX_ADR;
          end
        end
      end
      RX_ADR: begin
        if (noc_in_valid) begin
          adr_d = noc_in_flit;
          if (we_q) begin
            // A write that ends at the address flit has no data and is dropped.
            state_d = noc_in_last ? RX_HDR : RX_DAT;
          end else if (noc_in_last) begin
            state_d = WB_REQ;
          end else begin
            pend_d  = 1'b1;
            state_d = DRAIN;
          end
        end
      end
      RX_DAT: begin
        if (noc_in_valid) begin
          wdat_d = noc_in_flit;
          if (noc_in_last) begin
            state_d = WB_REQ;
          end else begin
            pend_d  = 1'b1;
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (noc_in_valid && noc_in_last) state_d = pend_q ? WB_REQ : RX_HDR;
      end
      WB_REQ: begin
        tmo_d = tmo_q + 10'd1;
        if (wb_err_i) begin
          // err takes priority over a simultaneous ack
          err_d   = 1'b1;
          state_d = TX_HDR;
        end else if (wb_ack_i) begin
          err_d   = 1'b0;
          rdat_d  = wb_dat_i;
          state_d = TX_HDR;
        end else if (wb_rty_i) begin
          if (rty_q < RTY_LIM) begin
            rty_d   = rty_q + 8'd1;
            state_d = RTY_GAP;
          end else begin
            err_d   = 1'b1;
            state_d = TX_HDR;
          end
        end else if (tmo_d == TMO_LIM) begin
          err_d   = 1'b1;
          state_d = TX_HDR;
        end
      end
      RTY_GAP: state_d = WB_REQ;
      TX_HDR: begin
        if (noc_out_ready) state_d = we_q ? RX_HDR : TX_DAT;
      end
      TX_DAT: begin
        if (noc_out_ready) state_d = RX_HDR;
      end
      default: state_d = RX_HDR;
    endcase
  end

  // Output decode. Every output is driven from state or from registered
  // fields, so the response flit stays stable while it waits for ready.
  assign noc_in_ready  = (state_q == RX_HDR) || (state_q == RX_ADR) ||
                         (state_q == RX_DAT) || (state_q == DRAIN);
  assign noc_out_valid = (state_q == TX_HDR) || (state_q == TX_DAT);
  assign noc_out_last  = (state_q == TX_DAT) || ((state_q == TX_HDR) && we_q);
  assign noc_out_flit  = (state_q == TX_DAT) ? (err_q ? 32'd0 : rdat_q)
                       : {src_q, CLASS_RSP, ID, we_q, err_q, sel_q, 13'd0};

  assign wb_cyc_o = (state_q == WB_REQ);
  assign wb_stb_o = (state_q == WB_REQ);
  assign wb_adr_o = adr_q;
  assign wb_dat_o = wdat_q;
  assign wb_sel_o = sel_q;
  assign wb_we_o  = we_q;
  assign wb_cti_o = 3'b000;
  assign wb_bte_o = 2'b00;

endmodule

// File: tb/tb_noc_wb_bridge.sv
// tb_noc_wb_bridge: directed test of noc_wb_bridge. Inputs change and
// outputs are sampled on the falling clock edge.
module tb_noc_wb_bridge;

  localparam logic [4:0] MY_ID   = 5'd7;
  localparam int         TMO     = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] noc_in_flit = '0;
  logic        noc_in_last = 1'b0;
  logic        noc_in_valid = 1'b0;
  logic        noc_in_ready;
  logic [31:0] noc_out_flit;
  logic        noc_out_last;
  logic        noc_out_valid;
  logic        noc_out_ready = 1'b1;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [2:0]  wb_cti_o;
  logic [1:0]  wb_bte_o;
  logic        wb_ack_i = 1'b0, wb_err_i = 1'b0, wb_rty_i = 1'b0;
  logic [31:0] wb_dat_i = '0;

  int tests_run = 0;
  int tests_failed = 0;

  noc_wb_bridge #(.FLIT_WIDTH(32), .ID(MY_ID), .TIMEOUT(TMO), .MAX_RTY(3)) dut (
    .clk(clk), .rst(rst),
    .noc_in_flit(noc_in_flit), .noc_in_last(noc_in_last),
    .noc_in_valid(noc_in_valid), .noc_in_ready(noc_in_ready),
    .noc_out_flit(noc_out_flit), .noc_out_last(noc_out_last),
    .noc_out_valid(noc_out_valid), .noc_out_ready(noc_out_ready),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i),
    .wb_dat_i(wb_dat_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mkhdr(input logic [4:0] dest, input logic [2:0] cls,
                                        input logic [4:0] src, input logic we,
                                        input logic err, input logic [3:0] sel);
    return {dest, cls, src, we, err, sel, 13'd0};
  endfunction

  task automatic cyc1();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Drive one request flit from a falling edge until it is accepted.
  task automatic send(input logic [31:0] f, input logic l);
    bit done = 0;
    noc_in_flit  = f;
    noc_in_last  = l;
    noc_in_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      if (noc_in_ready) done = 1;
      cyc1();
    end
    noc_in_valid = 1'b0;
    noc_in_last  = 1'b0;
    if (!done) check("send_timeout", 32'd0, 32'd1);
  endtask

  // Take one response flit; noc_out_ready is expected to be high.
  task automatic recv(output logic [31:0] f, output logic l);
    bit done = 0;
    f = 'x;
    l = 1'bx;
    for (int i = 0; i < 50 && !done; i++) begin
      if (noc_out_valid) begin
        f = noc_out_flit;
        l = noc_out_last;
        done = 1;
      end
      cyc1();
    end
    if (!done) check("recv_timeout", 32'd0, 32'd1);
  endtask

  // Present a single-cycle slave response.
  task automatic wb_resp(input logic a, input logic e, input logic r, input logic [31:0] d);
    wb_ack_i = a;
    wb_err_i = e;
    wb_rty_i = r;
    wb_dat_i = d;
    cyc1();
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    wb_rty_i = 1'b0;
  endtask

  task automatic send_read(input logic [4:0] src, input logic [3:0] sel, input logic [31:0] adr);
    send(mkhdr(5'd1, 3'd2, src, 1'b0, 1'b0, sel), 1'b0);
    send(adr, 1'b1);
  endtask

  logic [31:0] f, exph;
  logic        l;
  int          cnt;

  initial begin
    // ---- reset state
    #12;
    check("rst_in_ready", 32'(noc_in_ready), 32'd1);
    check("rst_cyc", 32'(wb_cyc_o), 32'd0);
    check("rst_out_valid", 32'(noc_out_valid), 32'd0);
    check("rst_adr", wb_adr_o, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    cyc1();

    // ---- write 0x100 <= 0xDEADBEEF, ack two cycles after stb rises
    send(mkhdr(5'd1, 3'd2, 5'd4, 1'b1, 1'b0, 4'hF), 1'b0);
    send(32'h0000_0100, 1'b0);
    send(32'hDEAD_BEEF, 1'b1);
    check("wr_cyc", 32'(wb_cyc_o), 32'd1);
    check("wr_stb", 32'(wb_stb_o), 32'd1);
    check("wr_we", 32'(wb_we_o), 32'd1);
    check("wr_adr", wb_adr_o, 32'h100);
    check("wr_dat", wb_dat_o, 32'hDEAD_BEEF);
    check("wr_sel", 32'(wb_sel_o), 32'hF);
    check("wr_cti_bte", {27'd0, wb_cti_o, wb_bte_o}, 32'd0);
    cyc1();
    check("wr_cyc_hold", 32'(wb_cyc_o), 32'd1);
    wb_resp(1'b1, 1'b0, 1'b0, 32'd0);
    check("wr_cyc_drop", 32'(wb_cyc_o), 32'd0);
    check("wr_rsp_valid", 32'(noc_out_valid), 32'd1);
    recv(f, l);
    check("wr_rsp_hdr", f, mkhdr(5'd4, 3'd3, MY_ID, 1'b1, 1'b0, 4'hF));
    check("wr_rsp_last", 32'(l), 32'd1);
    check("wr_b2b_ready", 32'(noc_in_ready), 32'd1);
    $display("[TB] txn write 0x100 data 0xdeadbeef -> hdr 0x%08h", f);

    // ---- read 0x200, immediate ack
    send_read(5'd9, 4'h3, 32'h0000_0200);
    check("rd_stb", 32'(wb_stb_o), 32'd1);
    check("rd_we", 32'(wb_we_o), 32'd0);
    check("rd_adr", wb_adr_o, 32'h200);
    wb_resp(1'b1, 1'b0, 1'b0, 32'h1234_5678);
    recv(f, l);
    check("rd_rsp_hdr", f, mkhdr(5'd9, 3'd3, MY_ID, 1'b0, 1'b0, 4'h3));
    check("rd_rsp_hdr_last", 32'(l), 32'd0);
    recv(f, l);
    check("rd_rsp_data", f, 32'h1234_5678);
    check("rd_rsp_data_last", 32'(l), 32'd1);
    $display("[TB] txn read 0x200 -> data 0x%08h", f);

    // ---- read with rty, rty, ack
    send_read(5'd2, 4'hF, 32'h0000_0240);
    for (int r = 0; r < 2; r++) begin
      wb_resp(1'b0, 1'b0, 1'b1, 32'd0);
      check("rty_gap", 32'(wb_cyc_o), 32'd0);
      cyc1();
      check("rty_reissue", 32'(wb_cyc_o), 32'd1);
    end
    wb_resp(1'b1, 1'b0, 1'b0, 32'h55AA_55AA);
    recv(f, l);
    check("rty_rsp_hdr", f, mkhdr(5'd2, 3'd3, MY_ID, 1'b0, 1'b0, 4'hF));
    recv(f, l);
    check("rty_rsp_data", f, 32'h55AA_55AA);
    $display("[TB] txn read 0x240 after 2 retries -> data 0x%08h", f);

    // ---- MAX_RTY+1 retries -> error
    send_read(5'd3, 4'h1, 32'h0000_0280);
    for (int r = 0; r < 4; r++) begin
      wb_resp(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
      check("rtyx_cyc_low", 32'(wb_cyc_o), 32'd0);
      if (r < 3) begin
        check("rtyx_no_rsp", 32'(noc_out_valid), 32'd0);
        cyc1();
        check("rtyx_reissue", 32'(wb_cyc_o), 32'd1);
      end
    end
    check("rtyx_rsp_valid", 32'(noc_out_valid), 32'd1);
    recv(f, l);
    check("rtyx_rsp_hdr", f, mkhdr(5'd3, 3'd3, MY_ID, 1'b0, 1'b1, 4'h1));
    recv(f, l);
    check("rtyx_rsp_data", f, 32'd0);
    $display("[TB] txn read 0x280 retries exhausted -> err");

    // ---- timeout: no slave response
    send_read(5'd5, 4'hC, 32'h0000_0300);
    cnt = 0;
    for (int i = 0; i < 100 && wb_cyc_o; i++) begin
      cnt++;
      cyc1();
    end
    check("tmo_cycles", 32'(cnt), 32'(TMO));
    recv(f, l);
    check("tmo_rsp_hdr", f, mkhdr(5'd5, 3'd3, MY_ID, 1'b0, 1'b1, 4'hC));
    recv(f, l);
    check("tmo_rsp_data", f, 32'd0);
    $display("[TB] txn read 0x300 timeout after %0d cycles", cnt);

    // ---- write with ack and err together -> err
    send(mkhdr(5'd1, 3'd2, 5'd6, 1'b1, 1'b0, 4'h5), 1'b0);
    send(32'h0000_0400, 1'b0);
    send(32'h0102_0304, 1'b1);
    wb_resp(1'b1, 1'b1, 1'b0, 32'd0);
    recv(f, l);
    check("ackerr_rsp_hdr", f, mkhdr(5'd6, 3'd3, MY_ID, 1'b1, 1'b1, 4'h5));
    check("ackerr_rsp_last", 32'(l), 32'd1);
    $display("[TB] txn write 0x400 ack+err -> hdr 0x%08h", f);

    // ---- class-5 packet is drained silently
    send(mkhdr(5'd1, 3'd5, 5'd4, 1'b0, 1'b0, 4'hF), 1'b0);
    send(32'h1111_1111, 1'b0);
    send(32'h2222_2222, 1'b0);
    send(32'h3333_3333, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check("cls5_no_rsp", 32'(noc_out_valid), 32'd0);
      check("cls5_no_cyc", 32'(wb_cyc_o), 32'd0);
      cyc1();
    end
    check("cls5_idle_ready", 32'(noc_in_ready), 32'd1);
    $display("[TB] txn class-5 packet dropped");

    // ---- read with two trailing flits
    send(mkhdr(5'd1, 3'd2, 5'd8, 1'b0, 1'b0, 4'hF), 1'b0);
    send(32'h0000_0500, 1'b0);
    check("drain_no_cyc", 32'(wb_cyc_o), 32'd0);
    send(32'hAAAA_AAAA, 1'b0);
    send(32'hBBBB_BBBB, 1'b1);
    check("drain_cyc", 32'(wb_cyc_o), 32'd1);
    check("drain_adr", wb_adr_o, 32'h500);
    wb_resp(1'b1, 1'b0, 1'b0, 32'hCAFE_F00D);
    recv(f, l);
    check("drain_rsp_hdr", f, mkhdr(5'd8, 3'd3, MY_ID, 1'b0, 1'b0, 4'hF));
    recv(f, l);
    check("drain_rsp_data", f, 32'hCAFE_F00D);
    $display("[TB] txn read 0x500 with trailing flits -> data 0x%08h", f);

    // ---- backpressure on the response
    noc_out_ready = 1'b0;
    send_read(5'd10, 4'h9, 32'h0000_0600);
    wb_resp(1'b1, 1'b0, 1'b0, 32'h0BAD_CAFE);
    exph = mkhdr(5'd10, 3'd3, MY_ID, 1'b0, 1'b0, 4'h9);
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", 32'(noc_out_valid), 32'd1);
      check("bp_flit", noc_out_flit, exph);
      cyc1();
    end
    noc_out_ready = 1'b1;
    recv(f, l);
    check("bp_rsp_hdr", f, exph);
    recv(f, l);
    check("bp_rsp_data", f, 32'h0BAD_CAFE);
    $display("[TB] txn read 0x600 under backpressure -> data 0x%08h", f);

    // ---- reset while in WB_REQ
    send_read(5'd11, 4'hF, 32'h0000_0700);
    check("rstreq_cyc_before", 32'(wb_cyc_o), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("rstreq_cyc_async", 32'(wb_cyc_o), 32'd0);
    check("rstreq_stb_async", 32'(wb_stb_o), 32'd0);
    check("rstreq_ready", 32'(noc_in_ready), 32'd1);
    @(negedge clk);
    cyc1();
    rst = 1'b1;
    cyc1();
    check("rstrel_ready", 32'(noc_in_ready), 32'd1);
    check("rstrel_valid", 32'(noc_out_valid), 32'd0);
    check("rstrel_cyc", 32'(wb_cyc_o), 32'd0);
    $display("[TB] txn reset during bus request");

    // ---- normal read after reset
    send_read(5'd12, 4'h6, 32'h0000_0800);
    check("post_adr", wb_adr_o, 32'h800);
    wb_resp(1'b1, 1'b0, 1'b0, 32'h8765_4321);
    recv(f, l);
    check("post_rsp_hdr", f, mkhdr(5'd12, 3'd3, MY_ID, 1'b0, 1'b0, 4'h6));
    recv(f, l);
    check("post_rsp_data", f, 32'h8765_4321);
    $display("[TB] txn read 0x800 after reset -> data 0x%08h", f);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
